xdist_sync_fifo: RTL
====================

# xdist_sync_fifo

Parametrised synchronous FIFO built on distributed (LUT) RAM: one write port, one read port, one clock. It is the next-generation replacement for the bare simple-dual-port distributed RAM wrapper. Pointer management, full/empty flags, fill count, programmable thresholds, error pulses and a selectable first-word-fall-through (FWFT) read mode are all built in. Used for shallow rate-decoupling and frame-header buffering in the switch datapath.

## Interface
- DATA_WIDTH, 32, word width in bits (1..256)
- FIFO_DEPTH, 64, words of storage; power of 2, 16..1024
- FWFT, 0, read mode: 0 = standard (dout one cycle after rd_en), 1 = first-word-fall-through
- PROG_FULL_THRESH, FIFO_DEPTH-4, prog_full asserts when data_count >= this value; legal 1..FIFO_DEPTH
- PROG_EMPTY_THRESH, 4, prog_empty asserts when data_count <= this value; legal 0..FIFO_DEPTH-1
- CNT_WIDTH, log2(FIFO_DEPTH)+1, derived; not to be overridden
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data
- full  out  1  no write accepted this cycle
- overflow  out  1  one-cycle pulse: previous cycle had wr_en while full
- rd_en  in  1  read request (standard mode) / pop acknowledge (FWFT)
- dout  out  DATA_WIDTH  read data, registered
- empty  out  1  no read accepted this cycle
- valid  out  1  dout holds a word (standard: pulse after accepted read; FWFT: equals !empty)
- underflow  out  1  one-cycle pulse: previous cycle had rd_en while empty
- data_count  out  CNT_WIDTH  words held, including the FWFT output register
- prog_full  out  1  threshold flag
- prog_empty  out  1  threshold flag

## Operation
- Storage: DEPTH x DATA_WIDTH distributed RAM. Synchronous write at wr_ptr, asynchronous read at rd_ptr, followed by a registered dout stage. No block RAM is inferred.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Accepted write: wr_en && !full. RAM[wr_ptr] <= din, and wr_ptr increments.
- Accepted read, standard mode: rd_en && !empty. dout <= RAM[rd_ptr], rd_ptr increments, valid = 1 next cycle, otherwise 0. dout holds its value when no read occurs.
- FWFT mode: the output register is filled automatically from RAM whenever it is empty or being popped and the RAM is non-empty.
  - empty = !(output register occupied).
  - An accepted read (rd_en && !empty) consumes the dout word.
- Rejected requests have no side effects other than the overflow/underflow pulse.
- data_count is incremented by accepted writes and decremented by accepted reads. Simultaneous accepted read and write leaves it unchanged.
- full = (data_count == FIFO_DEPTH). In FWFT mode, words in the RAM plus the output register never exceed FIFO_DEPTH.
- Standard mode: empty = (data_count == 0).
- prog_full and prog_empty are registered and computed from the next-state count, so they change on the same edge as data_count.
- Reset values:
  - full = 0, empty = 1, valid = 0, dout = 0, data_count = 0
  - prog_full = 0, prog_empty = 1, overflow = 0, underflow = 0
  - pointers = 0
- Reset mid-operation discards all contents immediately (asynchronous assertion). RAM contents are not cleared, but they are unreachable after reset.
- Release of rst_n is synchronised by the integrating design. The block accepts requests from the first clock edge after deassertion.

## Timing
- Write to empty deassert:
  - Standard mode: the write accepted at edge N drives empty low after edge N.
  - FWFT mode: empty goes low after edge N+1, with dout already valid.
- Read latency in standard mode: rd_en accepted at edge N means dout/valid are valid after edge N (presented in cycle N+1).
- FWFT back-to-back: rd_en held high with data available pops one word per cycle, with no bubbles.
- Full at count DEPTH-1: a write in that cycle sets full after the edge. A simultaneous read and write at full is treated as read accepted, write rejected, and overflow pulses.
- Simultaneous read and write on an empty FIFO:
  - Standard mode: write accepted, read rejected, underflow pulses.
  - FWFT mode: same behaviour, since empty is sampled before the edge.
- overflow and underflow are registered, each exactly one cycle per offending request, with no stretching.

## Test plan
- Reset then idle, DEPTH=16, FWFT=0:
  - empty=1, full=0, data_count=0, prog_empty=1, dout=0.
  - Hold rst_n low mid-burst: all flags return to reset values asynchronously.
- Fill and drain, DEPTH=16, FWFT=0:
  - Write 0x00..0x0F: full=1 after the 16th edge, prog_full=1 from count 12.
  - A 17th write produces overflow=1 for one cycle.
  - Read 16 words: outputs 0x00..0x0F in order, valid one cycle after each rd_en.
  - A 17th read produces underflow=1.
- Wrap-around: alternate write/read for 40 words with data_count held at 3. Pointers wrap twice and the data sequence stays intact.
- FWFT=1:
  - Single write 0xA5 to an empty FIFO: dout=0xA5 and empty=0 two edges after wr_en.
  - rd_en pops it and empty=1 on the next edge.
  - Continuous rd_en with writes every cycle gives one word per cycle and no gaps.
- Simultaneous operation at full, DEPTH=16: wr_en=rd_en=1 gives read accepted, overflow=1, data_count=15, full=0.
- Thresholds: PROG_FULL_THRESH=10, PROG_EMPTY_THRESH=2. prog_full rises on the edge making count 10 and falls at 9. prog_empty falls at 3 and rises at 2.

Source files
------------

// File: rtl/xdist_sync_fifo.sv
// Synchronous FIFO on distributed RAM with registered output stage,
// full/empty/threshold flags, error pulses and optional first-word-fall-through.
module xdist_sync_fifo #(
    parameter int DATA_WIDTH        = 32,
    parameter int FIFO_DEPTH        = 64,
    parameter int FWFT              = 0,
    parameter int PROG_FULL_THRESH  = FIFO_DEPTH - 4,
    parameter int PROG_EMPTY_THRESH = 4,
    parameter int CNT_WIDTH         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  valid,
    output logic                  underflow,
    output logic [CNT_WIDTH-1:0]  data_count,
    output logic                  prog_full,
    output logic                  prog_empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] PF_C    = CNT_WIDTH'(PROG_FULL_THRESH);
    localparam logic [CNT_WIDTH-1:0] PE_C    = CNT_WIDTH'(PROG_EMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  valid_q, valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  prog_full_q, prog_full_d;
    logic                  prog_empty_q, prog_empty_d;

    logic wr_acc, rd_acc, pop_ram;

    // In FWFT mode valid_q doubles as the output-register occupancy bit.
    always_comb begin
        wr_acc       = wr_en && !full_q;
        rd_acc       = rd_en && !empty_q;
        pop_ram      = rd_acc;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        dout_d       = dout_q;
        valid_d      = 1'b0;
        empty_d      = empty_q;

        if (FWFT != 0) begin
            pop_ram = (count_q != CNT_WIDTH'(valid_q)) && (!valid_q || rd_acc);
        end

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ram) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end

        count_d = count_q + CNT_WIDTH'(wr_acc) - CNT_WIDTH'(rd_acc);

        if (FWFT != 0) begin
            valid_d = pop_ram || (valid_q && !rd_acc);
            empty_d = !valid_d;
        end else begin
            valid_d = rd_acc;
            empty_d = (count_d == '0);
        end

        full_d       = (count_d == DEPTH_C);
        prog_full_d  = (count_d >= PF_C);
        prog_empty_d = (count_d <= PE_C);
        overflow_d   = wr_en && full_q;
        underflow_d  = rd_en && empty_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            valid_q      <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            valid_q      <= valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            prog_full_q  <= prog_full_d;
            prog_empty_q <= prog_empty_d;
        end
    end

    // Storage array carries no reset; stale words are unreachable after reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign full       = full_q;
    assign overflow   = overflow_q;
    assign dout       = dout_q;
    assign empty      = empty_q;
    assign valid      = valid_q;
    assign underflow  = underflow_q;
    assign data_count = count_q;
    assign prog_full  = prog_full_q;
    assign prog_empty = prog_empty_q;

endmodule
